// File: rtl/sd_outbound_arb.sv
// Round-robin arbiter sharing one outbound srdy/drdy channel among several
// requesters, with a registered 2-entry output buffer so every p_* output is
// a flop output and no c_drdy depends combinationally on p_drdy.
//
// Ports:
//   clk      - clock, all state updates on the rising edge
//   reset    - synchronous, active-low reset; also gates c_drdy/p_srdy
//   c_srdy   - per-requester source ready
//   c_drdy   - per-requester destination ready, at most one bit high
//   c_data   - requester i data at bits [i*width +: width]
//   c_eop    - per-requester end-of-packet (used only when pkt_mode=1)
//   p_srdy   - output word valid
//   p_drdy   - downstream ready
//   p_data   - output word data
//   p_eop    - output word end-of-packet (always 0 when pkt_mode=0)
//   p_grant  - index of the requester that sourced the output word
module sd_outbound_arb #(
    parameter int unsigned width     = 8,
    parameter int unsigned inputs    = 4,
    parameter int unsigned sel_width = 2,
    parameter bit          pkt_mode  = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [inputs-1:0]       c_srdy,
    output logic [inputs-1:0]       c_drdy,
    input  logic [inputs*width-1:0] c_data,
    input  logic [inputs-1:0]       c_eop,
    output logic                    p_srdy,
    input  logic                    p_drdy,
    output logic [width-1:0]        p_data,
    output logic                    p_eop,
    output logic [sel_width-1:0]    p_grant
);

    logic [1:0]           count_q, count_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic                 wr_ptr_q, wr_ptr_d;
    logic [sel_width-1:0] last_grant_q, last_grant_d;
    logic                 lock_q, lock_d;
    logic [sel_width-1:0] lock_idx_q, lock_idx_d;

    logic [width-1:0]     buf_data_q  [2];
    logic [1:0]           buf_eop_q;
    logic [sel_width-1:0] buf_grant_q [2];

    logic                 space;
    logic [sel_width-1:0] gnt;
    logic                 gnt_vld;
    logic                 c_xfer;
    logic                 p_xfer;

    // Space comes only from registered state, which keeps p_drdy out of the
    // c_drdy cone.
    assign space = (count_q < 2'd2);

    // Scan starts just after the last grant and wraps; a held lock overrides
    // the scan even when the locked requester is idle.
    always_comb begin
        int unsigned          idx;
        logic [sel_width-1:0] cand;
        idx     = 0;
        cand    = '0;
        gnt     = last_grant_q;
        gnt_vld = 1'b0;
        if (lock_q) begin
            gnt     = lock_idx_q;
            gnt_vld = c_srdy[lock_idx_q];
        end else begin
            for (int unsigned k = 1; k <= inputs; k++) begin
                idx = 32'(last_grant_q) + k;
                if (idx >= inputs) begin
                    idx = idx - inputs;
                end
                cand = sel_width'(idx);
                if (!gnt_vld && c_srdy[cand]) begin
                    gnt     = cand;
                    gnt_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        c_drdy = '0;
        c_xfer = space & gnt_vld & reset;
        if (c_xfer) begin
            c_drdy[gnt] = 1'b1;
        end
    end

    assign p_srdy  = (count_q != 2'd0) & reset;
    assign p_xfer  = p_srdy & p_drdy;
    assign p_data  = buf_data_q[rd_ptr_q];
    assign p_eop   = buf_eop_q[rd_ptr_q];
    assign p_grant = buf_grant_q[rd_ptr_q];

    always_comb begin
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        last_grant_d = last_grant_q;
        lock_d       = lock_q;
        lock_idx_d   = lock_idx_q;

        if (c_xfer) begin
            wr_ptr_d     = ~wr_ptr_q;
            last_grant_d = gnt;
            if (pkt_mode) begin
                lock_d     = ~c_eop[gnt];
                lock_idx_d = gnt;
            end
        end
        if (p_xfer) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        unique case ({c_xfer, p_xfer})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q      <= 2'd0;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            last_grant_q <= sel_width'(inputs - 1);
            lock_q       <= 1'b0;
            lock_idx_q   <= '0;
        end else begin
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            last_grant_q <= last_grant_d;
            lock_q       <= lock_d;
            lock_idx_q   <= lock_idx_d;
        end
    end

    // Payload storage needs no reset: it is only visible while count != 0.
    always_ff @(posedge clk) begin
        if (c_xfer) begin
            buf_data_q[wr_ptr_q]  <= c_data[gnt*width +: width];
            buf_eop_q[wr_ptr_q]   <= c_eop[gnt] & pkt_mode;
            buf_grant_q[wr_ptr_q] <= gnt;
        end
    end

endmodule
